flex_queue: RTL and testbench
=============================

Name: flex_queue

Overview:
- Parametrised successor to the fixed two-entry normal queue.
- Latency-insensitive val/rdy FIFO with configurable message width, depth and queue type (normal, pipe, bypass).
- Adds synchronous flush, occupancy output and almost-full flag.
- Sits between any two val/rdy stages in the section-8 queue designs.

Parameters:
p_msg_nbits, 32, message width in bits (>=1)
p_num_msgs, 4, queue depth in entries (>=1; need not be a power of two)
p_type, QUEUE_NORMAL, one of QUEUE_NORMAL / QUEUE_PIPE / QUEUE_BYPASS
p_afull_thresh, p_num_msgs-1, almost_full asserts when occupancy >= this (1..p_num_msgs)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous discard of all entries
istream_val  input  1  enqueue valid
istream_rdy  output  1  enqueue ready
istream_msg  input  p_msg_nbits  enqueue payload
ostream_val  output  1  dequeue valid
ostream_rdy  input  1  dequeue ready
ostream_msg  output  p_msg_nbits  dequeue payload (head entry, or istream_msg on bypass)
num_free_entries  output  $clog2(p_num_msgs+1)  free slots
almost_full  output  1  occupancy >= p_afull_thresh

Behaviour:
- Storage: circular buffer of p_num_msgs entries. Pointers enq_ptr and deq_ptr are max(1,$clog2(p_num_msgs)) bits. Count is $clog2(p_num_msgs+1) bits. Storage is not reset.
- Pointer wrap: ptr == p_num_msgs-1 -> 0, else ptr+1. Correct for non-power-of-two depth.
- Transfers: enq = istream_val & istream_rdy; deq = ostream_val & ostream_rdy.
- Reset (reset low, asynchronous):
  - ptrs=0, count=0.
  - istream_rdy=0, ostream_val=0, almost_full=0, num_free_entries=p_num_msgs.
  - After reset rises: istream_rdy=1 from the first cycle.
- Normal (QUEUE_NORMAL):
  - istream_rdy = !full; ostream_val = !empty; ostream_msg = buf[deq_ptr].
  - No combinational val/rdy path. Enq-to-deq latency 1 cycle.
- Pipe (QUEUE_PIPE):
  - istream_rdy = !full | ostream_rdy. When full, enq and deq may occur in the same cycle.
  - ostream_val as normal. Combinational path ostream_rdy -> istream_rdy.
- Bypass (QUEUE_BYPASS):
  - ostream_val = !empty | istream_val.
  - When empty, ostream_msg = istream_msg (0-cycle latency). If also deq, nothing is written and count is unchanged.
  - istream_rdy = !full. Combinational path istream_val -> ostream_val.
- Simultaneous enq and deq when not bypassing: write buf[enq_ptr], read head, advance both ptrs, count unchanged.
- Flush (high at a clock edge): ptrs=0, count=0 next cycle. While flush is high: istream_rdy=0 and ostream_val=0, so no transfers occur. Flush has priority over enq/deq.
- Outputs: num_free_entries = p_num_msgs - count; almost_full = (count >= p_afull_thresh). Both registered-state derived only; no combinational input dependence.
- Depth 1 (p_num_msgs=1):
  - Normal mode alternates full/empty and gives 50% throughput.
  - Pipe mode gives full throughput.
- Invariants (assert in sim): count <= p_num_msgs; no enq when full except pipe with deq; no deq when empty except bypass.
- Elaboration error if p_num_msgs==0, p_afull_thresh==0 or p_afull_thresh>p_num_msgs, or p_type is invalid.

Decomposition:
- Package sec08_queues_pkg: QUEUE_NORMAL=0, QUEUE_PIPE=1, QUEUE_BYPASS=2 as a 2-bit typedef queue_type_t; helper function for pointer width.
- Sub-module flex_queue_ctrl: pointers, count, full/empty, mode-dependent val/rdy, write enable, bypass select.
- Top holds the storage array and output mux.

Test Plan:
- Normal, depth 4, 32b: enqueue 0xA0..0xA3 with ostream_rdy=0 -> istream_rdy=0 after the 4th, num_free_entries=0, almost_full=1 from count=3. Then drain -> 0xA0..0xA3 in order.
- Depth 3 (non-power-of-two), both sides always ready, 10 messages 0..9 -> exact in-order output, 1-cycle latency, pointer wrap twice, num_free_entries stays 3/2 and never underflows.
- Pipe, depth 2, full with 0x11,0x22, ostream_rdy=1 and istream_val=1 with 0x33 -> istream_rdy=1 same cycle, 0x11 out, queue holds 0x22,0x33.
- Bypass, empty, istream_val=1 msg 0x5A, ostream_rdy=1 -> ostream_val=1, msg 0x5A same cycle, count stays 0. Repeat with ostream_rdy=0 -> entry stored, count=1.
- Flush with 2 entries held plus istream_val=1 -> next cycle count=0, num_free_entries=4, ostream_val=0, flushed-cycle message not stored.
- Assert reset low mid-stream (count=3), asynchronously between edges -> istream_rdy/ostream_val drop immediately. After release: empty, istream_rdy=1, stale data never appears.

Source files
------------

// File: rtl/sec08_queues_pkg.sv
// rtl/sec08_queues_pkg.sv - shared queue types and sizing helpers
package sec08_queues_pkg;

  typedef enum logic [1:0] {
    QUEUE_NORMAL = 2'd0,
    QUEUE_PIPE   = 2'd1,
    QUEUE_BYPASS = 2'd2
  } queue_type_t;

  // A one-entry queue still needs a one-bit pointer.
  function automatic int unsigned ptr_nbits(input int unsigned num_msgs);
    return (num_msgs > 1) ? $clog2(num_msgs) : 1;
  endfunction

endpackage

// File: rtl/flex_queue_ctrl.sv
// rtl/flex_queue_ctrl.sv - pointers, occupancy and mode-dependent handshake
module flex_queue_ctrl
  import sec08_queues_pkg::*;
#(
  parameter int unsigned p_num_msgs = 4,
  parameter queue_type_t p_type     = QUEUE_NORMAL
)(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  istream_val,
  output logic                                  istream_rdy,
  output logic                                  ostream_val,
  input  logic                                  ostream_rdy,
  output logic                                  wen,
  output logic [ptr_nbits(p_num_msgs)-1:0]      waddr,
  output logic [ptr_nbits(p_num_msgs)-1:0]      raddr,
  output logic                                  bypass_sel,
  output logic [$clog2(p_num_msgs+1)-1:0]       count
);

  localparam int unsigned c_pw = ptr_nbits(p_num_msgs);
  localparam int unsigned c_cw = $clog2(p_num_msgs + 1);

  logic [c_pw-1:0] enq_ptr;
  logic [c_pw-1:0] deq_ptr;
  logic            full;
  logic            empty;
  logic            enq;
  logic            deq;
  logic            buf_enq;
  logic            buf_deq;

  // Wrap explicitly so depths that are not a power of two work.
  function automatic logic [c_pw-1:0] wrap_inc(input logic [c_pw-1:0] p);
    return (p == c_pw'(p_num_msgs - 1)) ? '0 : p + c_pw'(1);
  endfunction

  assign full  = (count == c_cw'(p_num_msgs));
  assign empty = (count == '0);

  // Handshake per queue type; reset and flush hold both sides idle.
  always_comb begin
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    bypass_sel  = 1'b0;
    if (reset && !flush) begin
      if (p_type == QUEUE_PIPE) begin
        istream_rdy = !full || ostream_rdy;
        ostream_val = !empty;
      end else if (p_type == QUEUE_BYPASS) begin
        istream_rdy = !full;
        ostream_val = !empty || istream_val;
        bypass_sel  = empty;
      end else begin
        istream_rdy = !full;
        ostream_val = !empty;
      end
    end
  end

  assign enq     = istream_val && istream_rdy;
  assign deq     = ostream_val && ostream_rdy;
  // A bypassed message goes straight through and never touches storage.
  assign buf_enq = enq && !(bypass_sel && deq);
  assign buf_deq = deq && !empty;
  assign wen     = buf_enq;
  assign waddr   = enq_ptr;
  assign raddr   = deq_ptr;

  // Pointer and occupancy state; flush clears everything on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else if (flush) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (buf_enq) enq_ptr <= wrap_inc(enq_ptr);
      if (buf_deq) deq_ptr <= wrap_inc(deq_ptr);
      if (buf_enq && !buf_deq)      count <= count + c_cw'(1);
      else if (!buf_enq && buf_deq) count <= count - c_cw'(1);
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count <= c_cw'(p_num_msgs));
  a_no_enq_full: assert property (@(posedge clk) disable iff (!reset)
    !(full && enq && !(p_type == QUEUE_PIPE && deq)));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!reset)
    !(empty && deq && p_type != QUEUE_BYPASS));

endmodule

// File: rtl/flex_queue.sv
// rtl/flex_queue.sv - parametrised val/rdy queue with flush and occupancy
module flex_queue
  import sec08_queues_pkg::*;
#(
  parameter int unsigned p_msg_nbits    = 32,
  parameter int unsigned p_num_msgs     = 4,
  parameter queue_type_t p_type         = QUEUE_NORMAL,
  parameter int unsigned p_afull_thresh = p_num_msgs - 1
)(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             istream_val,
  output logic                             istream_rdy,
  input  logic [p_msg_nbits-1:0]           istream_msg,
  output logic                             ostream_val,
  input  logic                             ostream_rdy,
  output logic [p_msg_nbits-1:0]           ostream_msg,
  output logic [$clog2(p_num_msgs+1)-1:0]  num_free_entries,
  output logic                             almost_full
);

  localparam int unsigned c_pw = ptr_nbits(p_num_msgs);
  localparam int unsigned c_cw = $clog2(p_num_msgs + 1);

  if (p_msg_nbits == 0) begin : g_err_width
    $error("flex_queue: p_msg_nbits must be >= 1");
  end
  if (p_num_msgs == 0) begin : g_err_depth
    $error("flex_queue: p_num_msgs must be >= 1");
  end
  if (p_afull_thresh == 0 || p_afull_thresh > p_num_msgs) begin : g_err_afull
    $error("flex_queue: p_afull_thresh must be in 1..p_num_msgs");
  end
  if (p_type != QUEUE_NORMAL && p_type != QUEUE_PIPE && p_type != QUEUE_BYPASS) begin : g_err_type
    $error("flex_queue: invalid p_type");
  end

  logic [p_msg_nbits-1:0] mem [p_num_msgs];
  logic                   wen;
  logic [c_pw-1:0]        waddr;
  logic [c_pw-1:0]        raddr;
  logic                   bypass_sel;
  logic [c_cw-1:0]        count;

  flex_queue_ctrl #(
    .p_num_msgs (p_num_msgs),
    .p_type     (p_type)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .wen         (wen),
    .waddr       (waddr),
    .raddr       (raddr),
    .bypass_sel  (bypass_sel),
    .count       (count)
  );

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= istream_msg;
  end

  assign ostream_msg      = bypass_sel ? istream_msg : mem[raddr];
  assign num_free_entries = c_cw'(p_num_msgs) - count;
  assign almost_full      = (count >= c_cw'(p_afull_thresh));

endmodule

// File: tb/tb_flex_queue.sv
// tb/tb_flex_queue.sv - directed scoreboard bench for flex_queue
module tb_flex_queue;
  import sec08_queues_pkg::*;

  logic clk;
  logic reset;

  // n: normal depth 4, 32b
  logic        n_flush, n_ival, n_irdy, n_oval, n_ordy, n_afull;
  logic [31:0] n_imsg, n_omsg;
  logic [2:0]  n_nfree;
  // t: normal depth 3, 8b
  logic        t_flush, t_ival, t_irdy, t_oval, t_ordy, t_afull;
  logic [7:0]  t_imsg, t_omsg;
  logic [1:0]  t_nfree;
  // p: pipe depth 2, 8b
  logic        p_flush, p_ival, p_irdy, p_oval, p_ordy, p_afull;
  logic [7:0]  p_imsg, p_omsg;
  logic [1:0]  p_nfree;
  // b: bypass depth 4, 8b
  logic        b_flush, b_ival, b_irdy, b_oval, b_ordy, b_afull;
  logic [7:0]  b_imsg, b_omsg;
  logic [2:0]  b_nfree;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb [$];
  logic [31:0] e;

  flex_queue #(.p_msg_nbits(32), .p_num_msgs(4), .p_type(QUEUE_NORMAL), .p_afull_thresh(3)) u_n (
    .clk(clk), .reset(reset), .flush(n_flush), .istream_val(n_ival), .istream_rdy(n_irdy),
    .istream_msg(n_imsg), .ostream_val(n_oval), .ostream_rdy(n_ordy), .ostream_msg(n_omsg),
    .num_free_entries(n_nfree), .almost_full(n_afull));
  flex_queue #(.p_msg_nbits(8), .p_num_msgs(3), .p_type(QUEUE_NORMAL), .p_afull_thresh(2)) u_t (
    .clk(clk), .reset(reset), .flush(t_flush), .istream_val(t_ival), .istream_rdy(t_irdy),
    .istream_msg(t_imsg), .ostream_val(t_oval), .ostream_rdy(t_ordy), .ostream_msg(t_omsg),
    .num_free_entries(t_nfree), .almost_full(t_afull));
  flex_queue #(.p_msg_nbits(8), .p_num_msgs(2), .p_type(QUEUE_PIPE), .p_afull_thresh(1)) u_p (
    .clk(clk), .reset(reset), .flush(p_flush), .istream_val(p_ival), .istream_rdy(p_irdy),
    .istream_msg(p_imsg), .ostream_val(p_oval), .ostream_rdy(p_ordy), .ostream_msg(p_omsg),
    .num_free_entries(p_nfree), .almost_full(p_afull));
  flex_queue #(.p_msg_nbits(8), .p_num_msgs(4), .p_type(QUEUE_BYPASS), .p_afull_thresh(3)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .istream_val(b_ival), .istream_rdy(b_irdy),
    .istream_msg(b_imsg), .ostream_val(b_oval), .ostream_rdy(b_ordy), .ostream_msg(b_omsg),
    .num_free_entries(b_nfree), .almost_full(b_afull));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {n_flush, n_ival, n_ordy, t_flush, t_ival, t_ordy} = '0;
    {p_flush, p_ival, p_ordy, b_flush, b_ival, b_ordy} = '0;
    n_imsg = '0; t_imsg = '0; p_imsg = '0; b_imsg = '0;

    // Reset state
    n_ival = 1'b1; b_ival = 1'b1;
    #1;
    chk("rst_irdy", n_irdy, 0);
    chk("rst_oval", n_oval, 0);
    chk("rst_afull", n_afull, 0);
    chk("rst_nfree", n_nfree, 4);
    chk("rst_byp_oval", b_oval, 0);
    n_ival = 1'b0; b_ival = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rel_irdy", n_irdy, 1);
    tick();

    // Normal depth 4: fill with no consumer, then drain
    n_ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_ival = 1'b1; n_imsg = 32'hA0 + i;
      #1;
      chk("fill_irdy", n_irdy, 1);
      sb.push_back(n_imsg);
      tick();
      chk("fill_nfree", n_nfree, 3 - i);
      chk("fill_afull", n_afull, (i + 1 >= 3) ? 1 : 0);
    end
    n_imsg = 32'hFF;
    #1;
    chk("full_irdy", n_irdy, 0);
    n_ival = 1'b0; n_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = sb.pop_front();
      chk("drain_oval", n_oval, 1);
      chk("drain_msg", n_omsg, e);
      tick();
    end
    n_ordy = 1'b0;
    chk("drained_oval", n_oval, 0);
    chk("drained_nfree", n_nfree, 4);

    // Depth 3 streaming with both sides ready
    sb.delete();
    t_ordy = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      t_ival = (k < 10); t_imsg = 8'(k);
      #1;
      chk("d3_nfree", t_nfree, 3 - sb.size());
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("d3_oval", t_oval, 1);
        chk("d3_msg", t_omsg, e);
      end else begin
        chk("d3_oval_idle", t_oval, 0);
      end
      if (k < 10) begin
        chk("d3_irdy", t_irdy, 1);
        sb.push_back(32'(k));
      end
      tick();
    end
    t_ival = 1'b0;
    chk("d3_end_oval", t_oval, 0);

    // Pipe depth 2: enq and deq together while full
    sb.delete();
    p_ordy = 1'b0;
    p_ival = 1'b1; p_imsg = 8'h11; #1; chk("pipe_irdy0", p_irdy, 1); sb.push_back(32'h11); tick();
    p_imsg = 8'h22; #1; chk("pipe_irdy1", p_irdy, 1); sb.push_back(32'h22); tick();
    p_imsg = 8'h33; #1;
    chk("pipe_full_irdy", p_irdy, 0);
    p_ordy = 1'b1; #1;
    chk("pipe_comb_irdy", p_irdy, 1);
    e = sb.pop_front();
    chk("pipe_oval", p_oval, 1);
    chk("pipe_msg", p_omsg, e);
    sb.push_back(32'h33);
    tick();
    p_ival = 1'b0;
    chk("pipe_nfree", p_nfree, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      e = sb.pop_front();
      chk("pipe_drain_msg", p_omsg, e);
      tick();
    end
    chk("pipe_empty_oval", p_oval, 0);
    p_ordy = 1'b0;

    // Bypass: empty pass-through, then store when consumer stalls
    b_ival = 1'b1; b_imsg = 8'h5A; b_ordy = 1'b1; #1;
    chk("byp_oval", b_oval, 1);
    chk("byp_msg", b_omsg, 32'h5A);
    chk("byp_irdy", b_irdy, 1);
    tick();
    b_ival = 1'b0; #1;
    chk("byp_nfree", b_nfree, 4);
    chk("byp_idle_oval", b_oval, 0);
    b_ival = 1'b1; b_imsg = 8'h5B; b_ordy = 1'b0; #1;
    chk("byp_stall_oval", b_oval, 1);
    tick();
    b_ival = 1'b0; b_imsg = 8'h00; #1;
    chk("byp_stored_nfree", b_nfree, 3);
    chk("byp_stored_msg", b_omsg, 32'h5B);
    b_ordy = 1'b1; tick();
    b_ordy = 1'b0;
    chk("byp_drained_oval", b_oval, 0);

    // Flush with two entries plus an offered message
    n_ordy = 1'b0;
    n_ival = 1'b1; n_imsg = 32'hC0; tick();
    n_imsg = 32'hC1; tick();
    chk("pre_flush_nfree", n_nfree, 2);
    n_flush = 1'b1; n_imsg = 32'hEE; #1;
    chk("flush_irdy", n_irdy, 0);
    chk("flush_oval", n_oval, 0);
    tick();
    n_flush = 1'b0; n_ival = 1'b0; #1;
    chk("post_flush_nfree", n_nfree, 4);
    chk("post_flush_oval", n_oval, 0);
    chk("post_flush_afull", n_afull, 0);
    n_ival = 1'b1; n_imsg = 32'hD0; tick();
    n_ival = 1'b0; n_ordy = 1'b1; #1;
    chk("post_flush_msg", n_omsg, 32'hD0);
    tick();
    n_ordy = 1'b0;

    // Asynchronous reset with three entries held
    n_ival = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_imsg = 32'hB0 + i;
      tick();
    end
    n_ival = 1'b0; #1;
    chk("mid_afull", n_afull, 1);
    chk("mid_nfree", n_nfree, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_irdy", n_irdy, 0);
    chk("arst_oval", n_oval, 0);
    chk("arst_nfree", n_nfree, 4);
    chk("arst_afull", n_afull, 0);
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("arel_irdy", n_irdy, 1);
    chk("arel_oval", n_oval, 0);
    tick();
    n_ival = 1'b1; n_imsg = 32'hE0; tick();
    n_ival = 1'b0; n_ordy = 1'b1; #1;
    chk("arel_msg", n_omsg, 32'hE0);
    tick();
    chk("arel_empty", n_oval, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
